lsu_mem_master: RTL

//   Load/store initiator driving the single-port pmem interface (ren/raddr/rdata, wen/waddr/wdata/wstrb).

---
 rtl/lsu_mem_master.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_master
// Description : Load/store initiator for a single-port pmem interface.
//               Accepts one core request per valid/ready handshake, sequences
//               it through a wait-counter FSM, drives one-cycle read/write
//               strobes with byte lanes, and returns an extended load result.
//               Optional build macro: LSU_MISALIGN_CHECK_EN (when defined,
//               misaligned half/word requests are rejected with rsp_err).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
    parameter int MEM_WAIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb
);

    localparam logic [3:0] c_wait_last = 4'(MEM_WAIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_wen;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_req_fire;
    logic        w_req_err;
    logic        w_last;
    logic        w_rd_strobe;
    logic        w_wr_strobe;
    logic [1:0]  w_off;
    logic [15:0] w_lane;
    logic [31:0] w_load_ext;
    logic [3:0]  w_strb;

    assign w_req_fire = req_valid && (r_state == S_IDLE);
    assign w_last     = (r_state == S_ACCESS) && (r_cnt == c_wait_last);

    // Classify an incoming request as illegal (size 3, or misaligned when checked)
    always_comb begin
        w_req_err = (req_size == 2'd3);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((req_size == 2'd1) && req_addr[0])
            w_req_err = 1'b1;
        if ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
            w_req_err = 1'b1;
`else
        w_req_err = w_req_err;
`endif
    end

    // Byte offset within the word, masked to the natural alignment of the size
    always_comb begin
        w_off = 2'b00;
        case (r_size)
            2'd0:    w_off = r_addr[1:0];
            2'd1:    w_off = {r_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    assign w_lane = 16'(mem_rdata >> {w_off, 3'b000});

    // Sign/zero extend the selected load lane to 32 bits
    always_comb begin
        w_load_ext = 32'd0;
        case (r_size)
            2'd0:    w_load_ext = {{24{~r_unsigned & w_lane[7]}},  w_lane[7:0]};
            2'd1:    w_load_ext = {{16{~r_unsigned & w_lane[15]}}, w_lane[15:0]};
            2'd2:    w_load_ext = mem_rdata;
            default: w_load_ext = 32'd0;
        endcase
    end

    // Byte-lane strobes for the captured store
    always_comb begin
        w_strb = 4'b0000;
        case (r_size)
            2'd0:    w_strb = 4'b0001 << w_off;
            2'd1:    w_strb = 4'b0011 << w_off;
            2'd2:    w_strb = 4'b1111;
            default: w_strb = 4'b0000;
        endcase
    end

    // Replicate store data into every lane it may land in
    always_comb begin
        mem_wdata = r_wdata;
        case (r_size)
            2'd0:    mem_wdata = {4{r_wdata[7:0]}};
            2'd1:    mem_wdata = {2{r_wdata[15:0]}};
            default: mem_wdata = r_wdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next-state and handshake/strobe decode
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        w_rd_strobe = 1'b0;
        w_wr_strobe = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_state_nxt = w_req_err ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                if (r_cnt == c_wait_last) begin
                    w_rd_strobe = ~r_wen;
                    w_wr_strobe = r_wen;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, wait counter and response data registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= 4'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_wen      <= 1'b0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else if (w_req_fire) begin
            r_cnt      <= 4'd0;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wen      <= req_wen;
            r_rdata    <= 32'd0;
            r_err      <= w_req_err;
        end else if (r_state == S_ACCESS) begin
            r_cnt <= r_cnt + 4'd1;
            if (w_last)
                r_rdata <= r_wen ? 32'd0 : w_load_ext;
        end else if ((r_state == S_RESP) && rsp_ready) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end
    end

    // Strobes are suppressed combinationally while reset is held
    assign mem_ren   = w_rd_strobe && !reset;
    assign mem_wen   = w_wr_strobe && !reset;
    assign mem_wstrb = mem_wen ? w_strb : 4'b0000;
    assign mem_raddr = {r_addr[31:2], 2'b00};
    assign mem_waddr = {r_addr[31:2], 2'b00};
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire
